// File: rtl/pipe_valid_tracker.sv
// Per-stage valid tracker for the in-order pipeline: bubbles on stall, flushes on redirect/exception, counts retirements.
// Optional perf counters (bubble_cnt, flush_cnt) are built only when PIPE_VALID_PERF_EN is defined.

module pvt_stage #(
  parameter int IDX         = 1,
  parameter int STALL_STAGE = 1,
  parameter int BR_STAGE    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic exc_flush,
  input  logic redirect,
  input  logic stall,
  input  logic prev,
  output logic vld
);
  localparam bit KILL_ON_REDIR   = (IDX <= BR_STAGE);
  localparam bit HOLD_ON_STALL   = (IDX <= STALL_STAGE);
  localparam bit BUBBLE_ON_STALL = (IDX == STALL_STAGE + 1);

  always_ff @(posedge clk) begin
    if (rst)            vld <= 1'b0;
    else if (exc_flush) vld <= 1'b0;
    else if (redirect)  vld <= KILL_ON_REDIR ? 1'b0 : prev;
    else if (stall) begin
      if (HOLD_ON_STALL)        vld <= vld;
      else if (BUBBLE_ON_STALL) vld <= 1'b0;
      else                      vld <= prev;
    end
    else                vld <= prev;
  end
endmodule

module pipe_valid_tracker #(
  parameter int STAGES      = 5,
  parameter int STALL_STAGE = 1,
  parameter int BR_STAGE    = 2,
  parameter int PC_W        = 32,
  parameter int INST_BYTES  = 4,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              fetch_valid,
  input  logic [PC_W-1:0]   pc_cur,
  input  logic [PC_W-1:0]   pc_next,
  input  logic              br_req,
  input  logic              exc_flush,
  output logic              redirect,
  output logic [STAGES-2:0] stage_valid,
  output logic              retire,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  if (STAGES < 3 || STAGES > 16) begin : g_bad_stages
    $error("pipe_valid_tracker: STAGES must be 3..16");
  end
  if (STALL_STAGE < 1 || STALL_STAGE > STAGES-2) begin : g_bad_stall
    $error("pipe_valid_tracker: STALL_STAGE must be 1..STAGES-2");
  end
  if (BR_STAGE < STALL_STAGE || BR_STAGE > STAGES-2) begin : g_bad_br
    $error("pipe_valid_tracker: BR_STAGE must be STALL_STAGE..STAGES-2");
  end

  // pc_next == pc_cur under stall is IF holding its PC, not a jump
  logic [PC_W-1:0] pc_seq;
  assign pc_seq   = pc_cur + PC_W'(INST_BYTES);
  assign redirect = ((pc_next != pc_seq) && !((pc_next == pc_cur) && stall)) ||
                    (br_req && stage_valid[BR_STAGE-1]);

  logic [STAGES-2:0] chain;
  assign chain = {stage_valid[STAGES-3:0], fetch_valid};

  for (genvar k = 1; k < STAGES; k++) begin : g_stg
    pvt_stage #(.IDX(k), .STALL_STAGE(STALL_STAGE), .BR_STAGE(BR_STAGE)) u_stg (
      .clk       (clk),
      .rst       (rst),
      .exc_flush (exc_flush),
      .redirect  (redirect),
      .stall     (stall),
      .prev      (chain[k-1]),
      .vld       (stage_valid[k-1])
    );
  end

  assign retire = stage_valid[STAGES-2];

  // last-stage instruction commits even on a flushing edge
  always_ff @(posedge clk) begin
    if (rst)         retire_cnt <= '0;
    else if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
  end

`ifdef PIPE_VALID_PERF_EN
  logic [CNT_W-1:0] bubble_q, flush_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (!retire)                bubble_q <= bubble_q + CNT_W'(1);
      if (exc_flush || redirect)  flush_q  <= flush_q + CNT_W'(1);
    end
  end
  assign bubble_cnt = bubble_q;
  assign flush_cnt  = flush_q;
`else
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: doc/pipe_valid_tracker.md
# pipe_valid_tracker

Parametrised per-stage valid tracker for the in-order pipeline. Stage 0 (IF) is untracked; stages 1..STAGES-1 (ID, EX, MEM, WB at default) each carry one valid bit. The block detects control-flow redirects, inserts bubbles on stall, flushes on redirect or exception, and counts retirements. It sits beside the hazard unit and feeds the valid bits to every stage's write-enable gating.

## Interface
- STAGES, 5: total pipeline stages including IF; legal 3..16.
- STALL_STAGE, 1: last stage held on `stall`; legal 1..STAGES-2.
- BR_STAGE, 2: stage resolving branches, flushed on redirect; legal STALL_STAGE..STAGES-2, else elaboration fails.
- PC_W, 32: PC width.
- INST_BYTES, 4: sequential PC increment.
- CNT_W, 32: counter width.

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold stages 1..STALL_STAGE this cycle
- fetch_valid  in  1  IF presents an instruction this cycle
- pc_cur  in  PC_W  PC of instruction currently in IF
- pc_next  in  PC_W  PC selected for next fetch
- br_req  in  1  branch taken, resolved in BR_STAGE
- exc_flush  in  1  exception flush, kills all tracked stages
- redirect  out  1  combinational control-flow redirect
- stage_valid  out  STAGES-1  bit k-1 = stage k holds a live instruction
- retire  out  1  = stage_valid[STAGES-2]
- retire_cnt  out  CNT_W  retired-instruction count
- bubble_cnt  out  CNT_W  last-stage empty cycles (see Configuration)
- flush_cnt  out  CNT_W  flush events (see Configuration)

## Operation
- redirect = (pc_next != pc_cur + INST_BYTES && !(pc_next == pc_cur && stall)) || (br_req && stage_valid[BR_STAGE-1]).
- pc_cur + INST_BYTES computed modulo 2^PC_W: pc_cur = 0xFFFFFFFC, pc_next = 0x0 is sequential.
- Per-edge update, priority highest first:
  - rst: all stage_valid, all counters <= 0.
  - exc_flush: all stage_valid <= 0.
  - redirect: stages 1..BR_STAGE <= 0; stage k > BR_STAGE <= stage k-1 (resolving branch proceeds).
  - stall: stages 1..STALL_STAGE hold; stage STALL_STAGE+1 <= 0; stages above shift.
  - else: stage 1 <= fetch_valid; stage k <= stage k-1.
- Retirement: retire_cnt += 1 on every non-reset edge where retire = 1, including edges with exc_flush or redirect (last-stage instruction commits).
- All counters wrap modulo 2^CNT_W, no saturation.
- br_req with stage_valid[BR_STAGE-1] = 0 is ignored (bubble branch).

## Timing
- redirect: zero-latency combinational from inputs and stage_valid.
- stage_valid, counters: registered, one-cycle update latency.
- Instruction entering stage 1 at edge n reaches last stage at edge n+STAGES-2 absent stalls/flushes.
- Reset mid-operation: next edge clears everything regardless of other inputs; first post-reset edge may load stage 1.
- stall and redirect same cycle: redirect wins; stalled stages are cleared, not held.
- exc_flush and redirect same cycle: exc_flush wins; flush_cnt increments once.
- Outputs after reset: stage_valid = 0, retire = 0, all counters = 0; redirect follows inputs.

## Configuration
- Macro PIPE_VALID_PERF_EN.
- Defined: bubble_cnt += 1 per non-reset edge with retire = 0; flush_cnt += 1 per non-reset edge with exc_flush || redirect.
- Undefined: bubble_cnt and flush_cnt tied to 0, no registers inferred; retire_cnt always present.

## Test plan
- Defaults, rst 1 cycle, fetch_valid = 1, sequential PC from 0x100, no stall -> stage_valid 0001, 0011, 0111, 1111 on edges 1-4; retire_cnt = 6 after 10 edges.
- Full pipe, stall = 1 for 2 cycles, pc_next = pc_cur -> ID held, EX bubble propagates; redirect stays 0; retire drops for exactly 2 cycles, 2 edges later.
- Full pipe, br_req = 1 with EX valid -> redirect = 1 same cycle; next stage_valid = 1100 (MEM, WB live); flush_cnt = 1 (macro on).
- stall = 1 and br_req = 1 together -> stage_valid = 1100, not holding ID.
- exc_flush with WB valid -> stage_valid = 0000; retire_cnt still increments by 1; pc_cur = 0xFFFFFFFC, pc_next = 0 -> redirect = 0.
- STAGES = 7, STALL_STAGE = 2, BR_STAGE = 3, macro off -> stall bubbles stage 3 only; redirect clears stages 1-3; bubble_cnt and flush_cnt read 0.
